secuenciador_mac: RTL
=====================

# secuenciador_mac

Sequencer for the shared multiply-accumulate datapath (`Sumador`, N = 25) in the filter path. On a start pulse it walks a tap index over the external sample and coefficient stores and feeds one product per cycle into the MAC. It keeps the running sum in its own accumulator register, closing the loop through the MAC's `Sum_ext` input. At the end it latches the final 2N-bit sum and pulses `done`.

## Interface

Parameters:
- N, 25, operand width; must match the MAC's N.
- TAPS, 5, maximum number of taps per computation (≥1).
- AW, 3, tap address width; requires 2^AW ≥ TAPS.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- start  in  1  request a computation; sampled only in IDLE.
- n_taps  in  AW+1  taps to accumulate; sampled with an accepted `start`.
- addr  out  AW  tap index to the sample and coefficient stores (combinational-read stores).
- muestra  in  N  sample at `addr`.
- coef  in  N  coefficient at `addr`.
- mac_a  out  N  to MAC `Multiplicandos`.
- mac_b  out  N  to MAC `Constantes`.
- mac_acc  out  2N  to MAC `Sum_ext`.
- mac_res  in  2N  from MAC `Suma_G`.
- resultado  out  2N  registered final sum; held until the next completion.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `addr`=0, `mac_a`=`mac_b`=0, `mac_acc`=0.
  - With `start`=1: clear acc and idx to 0, latch `n_eff`, then go to RUN. If `n_eff`=0, go directly to DONE instead.
- `n_eff` = min(`n_taps`, TAPS). A value above TAPS is clamped, never an error.
- RUN:
  - `addr`=idx; `mac_a`=`muestra`; `mac_b`=`coef`; `mac_acc`=acc (all pass-through).
  - Each cycle: acc <= `mac_res`, idx <= idx+1.
  - When idx = `n_eff`−1: `resultado` <= `mac_res`, then go to DONE.
- DONE:
  - `done`=1 for exactly this cycle, `busy`=1, MAC outputs are 0.
  - Next state is IDLE unconditionally.
  - If `n_eff` was 0, `resultado` <= 0 on entry.
- Arithmetic:
  - Sum is unsigned, modulo 2^(2N); the MAC's wrap behaviour is accepted.
  - No saturation.
  - The block adds no width extension beyond 2N.
- `start` in RUN or DONE is ignored and not queued.
- `n_taps` changes after acceptance have no effect.
- `resultado` changes only on entry to DONE; it is stable otherwise.

## Timing

- Reset (asynchronous assert, any cycle, including mid-RUN):
  - State IDLE; acc, idx, `resultado` = 0.
  - `done`=`busy`=0; `addr`=0; `mac_a`=`mac_b`=`mac_acc`=0.
  - An in-flight computation is discarded with no `done`.
- Deassertion is synchronised externally; the first accepted `start` is on the first rising edge with `rst_n`=1.
- Start accepted at edge k (`n_eff`=K≥1):
  - RUN occupies the cycles after edges k+1 … k+K; tap i is presented in the cycle after edge k+1+i.
  - `resultado` is valid and `done`=1 in the cycle after edge k+K+1.
  - `busy` rises after edge k+1 and falls after edge k+K+2.
- Start at edge k with `n_eff`=0: `done`=1 after edge k+1, `resultado`=0.
- Back-to-back: the earliest next accepted `start` is at edge k+K+2, when the FSM is back in IDLE. Throughput is one computation per K+2 cycles.
- MAC path: `mac_a`, `mac_b`, `mac_acc` → `mac_res` is combinational within one cycle. Store read, multiply and add must close in one clk period.

## Test plan

- Reset: assert `rst_n`=0 mid-RUN → all outputs 0 the same cycle, no `done`. After release, a run with samples 1,1,1,1,1 and coefs 3,3,3,3,3 gives `resultado`=15.
- Nominal: `n_taps`=5, samples 1,2,3,4,5, coefs all 2, start at edge k → `addr` steps 0..4 after edges k+1..k+5, `done` after edge k+6, `resultado`=30, `busy` high for 6 cycles.
- Clamp and zero:
  - `n_taps`=7 with the nominal data → `resultado`=30, `done` after edge k+6.
  - `n_taps`=0 → `done` after edge k+1, `resultado`=0.
- Ignored start: pulse `start` during RUN and during DONE → no second computation, `resultado` unchanged, single `done` pulse.
- Width extremes:
  - `n_taps`=1, `muestra`=`coef`=2^25−1 → `resultado`=(2^25−1)^2 = 0x3FFFFFC000001.
  - `n_taps`=5 with the same values → result equals 5·(2^25−1)^2 mod 2^50.
- Back-to-back: a second start at edge k+7 with coefs 1 → `resultado` changes from 30 to 15 on the second `done` only. acc starts from 0 and carries nothing over from the first run.

Source files
------------

// File: rtl/secuenciador_mac_if.sv
// Bus between the MAC sequencer and its host: control, tap stores, MAC operand/result loop
// and the registered final sum.
interface secuenciador_mac_if #(
  parameter int N  = 25,
  parameter int AW = 3
);
  logic            start;
  logic [AW:0]     n_taps;
  logic [AW-1:0]   addr;
  logic [N-1:0]    muestra;
  logic [N-1:0]    coef;
  logic [N-1:0]    mac_a;
  logic [N-1:0]    mac_b;
  logic [2*N-1:0]  mac_acc;
  logic [2*N-1:0]  mac_res;
  logic [2*N-1:0]  resultado;
  logic            busy;
  logic            done;

  modport master (
    output start, n_taps, muestra, coef, mac_res,
    input  addr, mac_a, mac_b, mac_acc, resultado, busy, done
  );

  modport slave (
    input  start, n_taps, muestra, coef, mac_res,
    output addr, mac_a, mac_b, mac_acc, resultado, busy, done
  );
endinterface

// File: rtl/secuenciador_mac.sv
// Walks a tap index over the sample/coefficient stores, feeding one product per cycle into
// the external MAC and closing the accumulation loop through its Sum_ext input.
module secuenciador_mac #(
  parameter int N    = 25,
  parameter int TAPS = 5,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  secuenciador_mac_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2*N-1:0]  r_acc;
  logic [AW-1:0]   r_idx;
  logic [AW:0]     r_neff;
  logic [2*N-1:0]  r_res;
  logic [AW:0]     w_neff;
  logic            w_last;

  // Oversized requests are clamped to the tap store depth, never rejected.
  assign w_neff = (bus.n_taps > (AW+1)'(TAPS)) ? (AW+1)'(TAPS) : bus.n_taps;
  assign w_last = (({1'b0, r_idx} + (AW+1)'(1)) == r_neff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_neff  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_neff <= w_neff;
            if (w_neff == '0) r_res <= '0;
          end
        end
        RUN: begin
          r_acc <= bus.mac_res;
          r_idx <= r_idx + AW'(1);
          if (w_last) r_res <= bus.mac_res;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.addr    = '0;
    bus.mac_a   = '0;
    bus.mac_b   = '0;
    bus.mac_acc = '0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = (w_neff == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.addr    = r_idx;
        bus.mac_a   = bus.muestra;
        bus.mac_b   = bus.coef;
        bus.mac_acc = r_acc;
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.done      = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.resultado = r_res;

endmodule
